// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder:
// funct3 load/store widths and FSM states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction/extension,
// store byte-enables and lane-replicated store data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_ldata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be_b;
  logic [3:0]  w_be_h;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_word[31:16]
                            : i_word[15:0];
  assign w_be_b = 4'b0001 << i_lane;
  assign w_be_h = i_lane[1] ? 4'b1100 : 4'b0011;

  always_comb begin
    o_ldata = '0;
    o_be    = '0;
    o_wdata = '0;
    unique case (1'b1)
      (i_funct3 == F3_B): begin
        o_ldata = {{24{w_byte[7]}}, w_byte};
        o_be    = w_be_b;
        o_wdata = {4{i_wdata[7:0]}};
      end
      (i_funct3 == F3_BU): begin
        o_ldata = {24'b0, w_byte};
        o_be    = w_be_b;
        o_wdata = {4{i_wdata[7:0]}};
      end
      (i_funct3 == F3_H): begin
        o_ldata = {{16{w_half[15]}}, w_half};
        o_be    = w_be_h;
        o_wdata = {2{i_wdata[15:0]}};
      end
      (i_funct3 == F3_HU): begin
        o_ldata = {16'b0, w_half};
        o_be    = w_be_h;
        o_wdata = {2{i_wdata[15:0]}};
      end
      (i_funct3 == F3_W): begin
        o_ldata = i_word;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target: one request at a time,
// answered after WAIT_STATES cycles from local storage.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  state_t      r_state;
  state_t      w_next;
  logic        r_rdy;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_acc;
  logic        w_enter;
  logic        w_idle;
  logic        w_we;
  logic [2:0]  w_f3;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_off;
  logic        w_bad;
  logic        w_err;
  logic        w_wr;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_ldata;
  logic [3:0]  w_be;
  logic [31:0] w_sdata;

  assign w_acc   = req_valid & req_ready;
  assign w_enter = (w_next == S_RESP) &&
                   (r_state != S_RESP);

  // With zero wait states the response is built
  // from the live inputs on the accept edge.
  assign w_idle  = (r_state == S_IDLE);
  assign w_we    = w_idle ? req_we     : r_we;
  assign w_f3    = w_idle ? req_funct3 : r_f3;
  assign w_addr  = w_idle ? req_addr   : r_addr;
  assign w_wdata = w_idle ? req_wdata  : r_wdata;

  assign w_off = w_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];

  always_comb begin
    w_bad = 1'b1;
    unique case (1'b1)
      (w_f3 == F3_B),
      (w_f3 == F3_BU): w_bad = 1'b0;
      (w_f3 == F3_H),
      (w_f3 == F3_HU): w_bad = w_addr[0];
      (w_f3 == F3_W):  w_bad = |w_addr[1:0];
      default:         w_bad = 1'b1;
    endcase
  end

  assign w_err  = w_bad | (w_off >= SPAN);
  assign w_wr   = w_enter & w_we & ~w_err;
  assign w_word = r_mem[w_idx];

  dmem_lane_align u_align (
    .i_word   (w_word),
    .i_wdata  (w_wdata),
    .i_lane   (w_addr[1:0]),
    .i_funct3 (w_f3),
    .o_ldata  (w_ldata),
    .o_be     (w_be),
    .o_wdata  (w_sdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc)
        w_next = (WS == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1)
        w_next = S_RESP;
      S_RESP: if (rsp_ready)
        w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_idle & r_rdy;
    rsp_valid = (r_state == S_RESP);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_idle && w_acc) begin
        r_cnt   <= WS;
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter) begin
        r_err   <= w_err;
        r_rdata <= (w_err | w_we) ? 32'd0 : w_ldata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_sdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with scoreboard,
// plus back-pressure, mid-transaction reset and zero-wait runs.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(.WAIT_STATES(1)) u_a (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_funct3(a_req_funct3),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.WAIT_STATES(0)) u_b (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[20];
  int pass_n = 0;
  int tot_n  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(logic we, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic e);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a;
    v.wdata = wd; v.rd = rd; v.err = e;
    return v;
  endfunction

  task automatic req(input string nm, input vec_t v);
    exp_t e;
    chk({nm, " req_ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid  = 1'b1;
    a_req_we     = v.we;
    a_req_funct3 = v.f3;
    a_req_addr   = v.addr;
    a_req_wdata  = v.wdata;
    e.rd = v.rd; e.err = v.err;
    sbq.push_back(e);
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic rsp(input string nm);
    int n;
    exp_t e;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({nm, " rdata"}, a_rsp_rdata, e.rd);
      chk({nm, " err"}, 32'(a_rsp_err), 32'(e.err));
    end else begin
      chk({nm, " scoreboard"}, 32'd0, 32'd1);
    end
  endtask

  task automatic run(input string nm, input vec_t v);
    req(nm, v);
    rsp(nm);
    @(posedge CLK); #1;
  endtask

  task automatic b_xfer(input string nm, input logic we,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] rd);
    b_req_valid  = 1'b1;
    b_req_we     = we;
    b_req_funct3 = f3;
    b_req_addr   = a;
    b_req_wdata  = wd;
    @(posedge CLK); #1;
    b_req_valid = 1'b0;
    chk({nm, " valid"}, 32'(b_rsp_valid), 32'd1);
    chk({nm, " rdata"}, b_rsp_rdata, rd);
    chk({nm, " err"}, 32'(b_rsp_err), 32'd0);
    @(posedge CLK); #1;
    chk({nm, " idle"}, 32'(b_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0);
    vt[1]  = mk(0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 0);
    vt[2]  = mk(1, F3_B,  32'h11, 32'h7F, 32'h0, 0);
    vt[3]  = mk(0, F3_B,  32'h11, 32'h0, 32'h0000007F, 0);
    vt[4]  = mk(0, F3_W,  32'h10, 32'h0, 32'hDEAD7FEF, 0);
    vt[5]  = mk(1, F3_W,  32'h20, 32'h0, 32'h0, 0);
    vt[6]  = mk(1, F3_H,  32'h20, 32'h80FF, 32'h0, 0);
    vt[7]  = mk(0, F3_H,  32'h20, 32'h0, 32'hFFFF80FF, 0);
    vt[8]  = mk(0, F3_HU, 32'h20, 32'h0, 32'h000080FF, 0);
    vt[9]  = mk(0, F3_B,  32'h20, 32'h0, 32'hFFFFFFFF, 0);
    vt[10] = mk(0, F3_B,  32'h21, 32'h0, 32'hFFFFFF80, 0);
    vt[11] = mk(0, F3_BU, 32'h21, 32'h0, 32'h00000080, 0);
    vt[12] = mk(0, F3_W,  32'h22, 32'h0, 32'h0, 1);
    vt[13] = mk(1, F3_H,  32'h21, 32'hAAAA, 32'h0, 1);
    vt[14] = mk(0, F3_W,  32'h1000, 32'h0, 32'h0, 1);
    vt[15] = mk(0, 3'b011, 32'h20, 32'h0, 32'h0, 1);
    vt[16] = mk(0, F3_W,  32'h20, 32'h0, 32'h000080FF, 0);
    vt[17] = mk(1, F3_W,  32'h30, 32'hCAFEF00D, 32'h0, 0);
    vt[18] = mk(0, F3_HU, 32'h32, 32'h0, 32'h0000CAFE, 0);
    vt[19] = mk(0, F3_B,  32'h33, 32'h0, 32'hFFFFFFCA, 0);

    RST_N = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0;
    a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0;
    b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst req_ready", 32'(a_req_ready), 32'd0);
    chk("rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(a_rsp_err), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post-rst req_ready", 32'(a_req_ready), 32'd1);

    for (int i = 0; i < 20; i++)
      run($sformatf("vec%0d", i), vt[i]);

    // Back-pressure: response held while a new request waits.
    a_rsp_ready = 1'b0;
    req("hold", mk(0, F3_W, 32'h10, 0, 32'hDEAD7FEF, 0));
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_req_funct3 = F3_W;
    a_req_addr  = 32'h20;
    rsp("hold");
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("hold%0d valid", k), 32'(a_rsp_valid), 32'd1);
      chk($sformatf("hold%0d rdata", k), a_rsp_rdata, 32'hDEAD7FEF);
      chk($sformatf("hold%0d err", k), 32'(a_rsp_err), 32'd0);
      chk($sformatf("hold%0d req_ready", k), 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("hold release valid", 32'(a_rsp_valid), 32'd0);
    chk("hold release req_ready", 32'(a_req_ready), 32'd1);
    begin
      exp_t e;
      e.rd = 32'h000080FF; e.err = 1'b0;
      sbq.push_back(e);
    end
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    rsp("pending");
    @(posedge CLK); #1;

    // Reset during WAIT discards the store.
    req("rststore", mk(1, F3_W, 32'h30, 32'h12345678, 0, 0));
    RST_N = 1'b0;
    sbq.delete();
    #1;
    chk("midrst rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(a_req_ready), 32'd0);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("midrst hold valid", 32'(a_rsp_valid), 32'd0);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("midrst after valid", 32'(a_rsp_valid), 32'd0);
    chk("midrst after rdata", a_rsp_rdata, 32'd0);
    run("reload30", mk(0, F3_W, 32'h30, 0, 32'hCAFEF00D, 0));

    b_xfer("ws0 sw", 1, F3_W, 32'h40, 32'hA5A55A5A, 32'h0);
    b_xfer("ws0 lw", 0, F3_W, 32'h40, 32'h0, 32'hA5A55A5A);
    b_xfer("ws0 lhu", 0, F3_HU, 32'h42, 32'h0, 32'h0000A5A5);
    b_xfer("ws0 lb", 0, F3_B, 32'h41, 32'h0, 32'h0000005A);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
